bias_add_ctrl: RTL and testbench

BIAS_ADD_CTRL -- requirements
Module: bias_add_ctrl

---
 rtl/bias_add_ctrl_pkg.sv | 17 +
 rtl/bias_vec_fifo.sv | 52 +++++
 rtl/bias_add_ctrl.sv | 111 +++++++++++
 tb/tb_bias_add_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_ctrl_pkg.sv
// Accelerator-wide constants shared by the bias controller and the bias/psum datapath.
package bias_add_ctrl_pkg;

  localparam int ACC_BITWIDTH = 32;
  localparam int ACC_LANES    = 16;
  localparam int ACC_GRP_W    = 16;

  // Signed saturation limits for a lane of bw bits, zero-extended to 64 bits
  function automatic logic [63:0] sat_max(input int bw);
    return (64'd1 << (bw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int bw);
    return 64'd1 << (bw - 1);
  endfunction

endpackage

// File: rtl/bias_vec_fifo.sv
// Bias vector FIFO; a write while full is taken only if a read frees a slot in the same cycle.
module bias_vec_fifo
  import bias_add_ctrl_pkg::*;
#(
  parameter int W     = ACC_BITWIDTH * ACC_LANES,
  parameter int DEPTH = 8
) (
  input  logic                       clk_data,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_data) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bias_add_ctrl.sv
// Per-group bias add: pops a bias vector per channel group, adds it to each psum beat
// and saturates, with a fixed two-stage pipeline and no output backpressure.
module bias_add_ctrl
  import bias_add_ctrl_pkg::*;
#(
  parameter int BITWIDTH   = ACC_BITWIDTH,
  parameter int LANES      = ACC_LANES,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_data,
  input  logic                          rst_n,
  input  logic                          fifo_wr_en,
  input  logic [BITWIDTH*LANES-1:0]     fifo_wr_data,
  input  logic [ACC_GRP_W-1:0]          beats_per_grp_1,
  input  logic                          psum_in_vld,
  input  logic [BITWIDTH*LANES-1:0]     psum_in,
  output logic                          psum_in_rdy,
  output logic                          out_vld,
  output logic [BITWIDTH*LANES-1:0]     out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          fifo_full,
  output logic                          ovf_err
);

  localparam int STAGES = 2;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [BITWIDTH-1:0] SAT_MAX = BITWIDTH'(sat_max(BITWIDTH));
  localparam logic [BITWIDTH-1:0] SAT_MIN = BITWIDTH'(sat_min(BITWIDTH));

  logic [0:0]                           state;
  logic [LANES-1:0][BITWIDTH-1:0]       cur_bias;
  logic [LANES-1:0][BITWIDTH-1:0]       psum_lanes;
  logic [LANES-1:0][BITWIDTH:0]         sum_q;
  logic [LANES-1:0][BITWIDTH-1:0]       out_q;
  logic [ACC_GRP_W-1:0]                 grp_len, beat_cnt;
  logic [STAGES:1]                      vld_pipe;
  logic [BITWIDTH*LANES-1:0]            fifo_rd_data;
  logic                                 fifo_empty;
  logic                                 accept, last_beat, pop;

  assign psum_lanes  = psum_in;
  assign psum_in_rdy = (state == ST_HOLD);
  assign accept      = psum_in_vld && psum_in_rdy;
  assign last_beat   = (beat_cnt == grp_len);
  // Load from FIFO head only; a same-cycle write never bypasses into cur_bias
  assign pop         = !fifo_empty && ((state == ST_EMPTY) || (accept && last_beat));
  assign out_vld     = vld_pipe[STAGES];
  assign out_data    = out_q;

  bias_vec_fifo #(
    .W     (BITWIDTH * LANES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_data (clk_data),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr_en),
    .wr_data  (fifo_wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      cur_bias <= '0;
      grp_len  <= '0;
      beat_cnt <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (fifo_wr_en && fifo_full && !pop) ovf_err <= 1'b1;
      if (pop) begin
        state    <= ST_HOLD;
        cur_bias <= fifo_rd_data;
        grp_len  <= beats_per_grp_1;
        beat_cnt <= '0;
      end else if (accept && last_beat) begin
        state    <= ST_EMPTY;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      sum_q    <= '0;
      out_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      for (int k = 0; k < LANES; k++) begin
        if (accept)
          sum_q[k] <= {psum_lanes[k][BITWIDTH-1], psum_lanes[k]}
                    + {cur_bias[k][BITWIDTH-1], cur_bias[k]};
        // Top two bits disagree only when the 33-bit sum left the signed 32-bit range
        if (vld_pipe[1]) begin
          if (sum_q[k][BITWIDTH] != sum_q[k][BITWIDTH-1])
            out_q[k] <= sum_q[k][BITWIDTH] ? SAT_MIN : SAT_MAX;
          else
            out_q[k] <= sum_q[k][BITWIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_bias_add_ctrl.sv
// Directed bench for bias_add_ctrl: group sequencing, saturation, FIFO full/overflow, reset.
module tb_bias_add_ctrl;

  localparam int BW = 32;
  localparam int LN = 16;
  localparam int FD = 8;
  localparam int VW = BW * LN;

  logic          clk_data;
  logic          rst_n;
  logic          fifo_wr_en;
  logic [VW-1:0] fifo_wr_data;
  logic [15:0]   beats_per_grp_1;
  logic          psum_in_vld;
  logic [VW-1:0] psum_in;
  logic          psum_in_rdy;
  logic          out_vld;
  logic [VW-1:0] out_data;
  logic [3:0]    fifo_cnt;
  logic          fifo_full;
  logic          ovf_err;

  int total;
  int bad;

  bias_add_ctrl #(.BITWIDTH(BW), .LANES(LN), .FIFO_DEPTH(FD)) dut (
    .clk_data        (clk_data),
    .rst_n           (rst_n),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
    .beats_per_grp_1 (beats_per_grp_1),
    .psum_in_vld     (psum_in_vld),
    .psum_in         (psum_in),
    .psum_in_rdy     (psum_in_rdy),
    .out_vld         (out_vld),
    .out_data        (out_data),
    .fifo_cnt        (fifo_cnt),
    .fifo_full       (fifo_full),
    .ovf_err         (ovf_err)
  );

  initial clk_data = 1'b0;
  always #5 clk_data = ~clk_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_data);
    #1;
  endtask

  function automatic logic [BW-1:0] lane(input logic [VW-1:0] v, input int k);
    return v[k*BW +: BW];
  endfunction

  function automatic logic [VW-1:0] ramp(input logic [BW-1:0] base);
    logic [VW-1:0] v;
    for (int k = 0; k < LN; k++) v[k*BW +: BW] = base + BW'(k);
    return v;
  endfunction

  function automatic logic [VW-1:0] fill(input logic [BW-1:0] val);
    logic [VW-1:0] v;
    for (int k = 0; k < LN; k++) v[k*BW +: BW] = val;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_wr_en = 1'b0;
    psum_in_vld = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [VW-1:0] v;
    int exp_cnt;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_wr_data = '0;
    beats_per_grp_1 = '0;
    psum_in_vld = 1'b0;
    psum_in = '0;
    step();
    step();

    chk("rst_rdy",  psum_in_rdy, 0);
    chk("rst_vld",  out_vld, 0);
    chk("rst_data", out_data[63:0], 0);
    chk("rst_cnt",  fifo_cnt, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf",  ovf_err, 0);
    rst_n = 1'b1;
    step();

    // Test 1: four-beat group, bias lane k = 100+k, psum 5
    beats_per_grp_1 = 16'd3;
    fifo_wr_data = ramp(32'd100);
    fifo_wr_en = 1'b1;
    step();
    fifo_wr_en = 1'b0;
    chk("t1_cnt_wr", fifo_cnt, 1);
    chk("t1_nobypass", psum_in_rdy, 0);
    step();
    chk("t1_rdy_load", psum_in_rdy, 1);
    chk("t1_cnt_load", fifo_cnt, 0);
    psum_in = fill(32'd5);
    psum_in_vld = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c == 3) psum_in_vld = 1'b0;
      chk($sformatf("t1_rdy_c%0d", c), psum_in_rdy, (c < 3));
      chk($sformatf("t1_vld_c%0d", c), out_vld, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) begin
        chk($sformatf("t1_l0_c%0d", c), lane(out_data, 0), 105);
        chk($sformatf("t1_l15_c%0d", c), lane(out_data, 15), 120);
      end
    end
    chk("t1_hold", lane(out_data, 0), 105);

    // Test 2: saturation both ways, plus in-range positive and negative lanes
    do_reset();
    beats_per_grp_1 = 16'd1;
    v = '0;
    v[0*BW +: BW] = 32'h7FFF_FFF0;
    v[1*BW +: BW] = 32'h8000_0000;
    v[3*BW +: BW] = 32'hFFFF_FFF6;
    fifo_wr_data = v;
    fifo_wr_en = 1'b1;
    step();
    fifo_wr_en = 1'b0;
    step();
    v = '0;
    v[0*BW +: BW] = 32'h0000_0020;
    v[1*BW +: BW] = 32'hFFFF_FFFF;
    v[2*BW +: BW] = 32'h0000_0007;
    v[3*BW +: BW] = 32'h0000_0003;
    psum_in = v;
    psum_in_vld = 1'b1;
    step();
    psum_in_vld = 1'b0;
    step();
    chk("t2_vld", out_vld, 1);
    chk("t2_satpos", lane(out_data, 0), 32'h7FFF_FFFF);
    chk("t2_satneg", lane(out_data, 1), 32'h8000_0000);
    chk("t2_plain",  lane(out_data, 2), 32'h0000_0007);
    chk("t2_neg",    lane(out_data, 3), 32'hFFFF_FFF9);

    // Test 3/5: fill the FIFO behind one loaded bias
    do_reset();
    beats_per_grp_1 = 16'd0;
    for (int i = 0; i < 9; i++) begin
      fifo_wr_data = ramp(32'd1000 + 32'(i));
      fifo_wr_en = 1'b1;
      step();
      exp_cnt = (i == 0) ? 1 : i;
      chk($sformatf("t3_cnt_w%0d", i), fifo_cnt, exp_cnt);
    end
    fifo_wr_en = 1'b0;
    chk("t3_full", fifo_full, 1);
    chk("t3_ovf_none", ovf_err, 0);
    chk("t3_rdy", psum_in_rdy, 1);

    // Last beat pops while a write lands on the full FIFO
    psum_in = fill(32'd1);
    psum_in_vld = 1'b1;
    fifo_wr_data = ramp(32'd2000);
    fifo_wr_en = 1'b1;
    step();
    psum_in_vld = 1'b0;
    fifo_wr_en = 1'b0;
    chk("t5_cnt", fifo_cnt, 8);
    chk("t5_ovf", ovf_err, 0);
    chk("t5_full", fifo_full, 1);
    step();
    chk("t5_vld", out_vld, 1);
    chk("t5_data", lane(out_data, 0), 1001);

    // Write while full with no pop is dropped
    fifo_wr_en = 1'b1;
    step();
    fifo_wr_en = 1'b0;
    chk("t3_ovf_set", ovf_err, 1);
    chk("t3_cnt_drop", fifo_cnt, 8);
    psum_in_vld = 1'b1;
    step();
    psum_in_vld = 1'b0;
    step();
    chk("t3_order", lane(out_data, 0), 1002);
    chk("t3_cnt_pop", fifo_cnt, 7);
    chk("t3_ovf_sticky", ovf_err, 1);

    // Test 4: single-beat groups A then B, back to back
    do_reset();
    beats_per_grp_1 = 16'd0;
    fifo_wr_data = ramp(32'd10);
    fifo_wr_en = 1'b1;
    step();
    fifo_wr_data = ramp(32'd50);
    step();
    fifo_wr_en = 1'b0;
    chk("t4_rdy0", psum_in_rdy, 1);
    chk("t4_cnt0", fifo_cnt, 1);
    psum_in = fill(32'd2);
    psum_in_vld = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 1) psum_in_vld = 1'b0;
      chk($sformatf("t4_rdy_c%0d", c), psum_in_rdy, (c == 0));
      chk($sformatf("t4_vld_c%0d", c), out_vld, (c == 1 || c == 2));
      if (c == 1) chk("t4_dataA", lane(out_data, 0), 12);
      if (c == 2) chk("t4_dataB", lane(out_data, 0), 52);
    end

    // Test 6: reset mid-group with beats in flight and 3 entries queued
    do_reset();
    beats_per_grp_1 = 16'd3;
    for (int i = 0; i < 4; i++) begin
      fifo_wr_data = ramp(32'd300 + 32'(i));
      fifo_wr_en = 1'b1;
      step();
    end
    fifo_wr_en = 1'b0;
    chk("t6_cnt_q", fifo_cnt, 3);
    psum_in = fill(32'd9);
    psum_in_vld = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  out_vld, 0);
    chk("t6_rst_data", out_data[63:0], 0);
    chk("t6_rst_rdy",  psum_in_rdy, 0);
    chk("t6_rst_cnt",  fifo_cnt, 0);
    chk("t6_rst_full", fifo_full, 0);
    chk("t6_rst_ovf",  ovf_err, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("t6_quiet_vld_c%0d", c), out_vld, 0);
      chk($sformatf("t6_quiet_rdy_c%0d", c), psum_in_rdy, 0);
    end
    psum_in_vld = 1'b0;
    beats_per_grp_1 = 16'd0;
    fifo_wr_data = ramp(32'd7);
    fifo_wr_en = 1'b1;
    step();
    fifo_wr_en = 1'b0;
    step();
    psum_in = fill(32'd1);
    psum_in_vld = 1'b1;
    step();
    psum_in_vld = 1'b0;
    step();
    chk("t6_fresh_vld", out_vld, 1);
    chk("t6_fresh_data", lane(out_data, 0), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
